// File: rtl/oled_spi_arbiter_pkg.sv
// Shared definitions for the OLED SPI arbiter: FSM state encoding and default timing.
package oled_spi_arbiter_pkg;

    localparam int CLK_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/oled_spi_shifter.sv
// SPI byte serializer: sclk idles high, sdo changes on falling edges, MSB first.
module oled_spi_shifter
    import oled_spi_arbiter_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       sclk,
    output logic       sdo,
    output logic       done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       active;
    logic       div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);
    // Asserted during the final cycle of the last high-going half period.
    assign done     = active && !sclk && div_wrap && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b1;
            sdo     <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= tx_byte;
            sclk    <= 1'b1;
        end else if (active) begin
            if (div_wrap) begin
                div_cnt <= '0;
                if (sclk) begin
                    sclk  <= 1'b0;
                    sdo   <= shreg[7];
                    shreg <= {shreg[6:0], 1'b0};
                end else begin
                    sclk    <= 1'b1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Two-requester arbiter for a shared OLED SPI link with burst locking and round-robin ties.
module oled_spi_arbiter
    import oled_spi_arbiter_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_dc,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_dc,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       sclk,
    output logic       sdo,
    output logic       dc,
    output logic [1:0] grant,
    output logic       busy
);

    localparam logic [7:0] GAP_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    state_t     next_state;
    logic       last_ptr;
    logic       last_cap;
    logic [7:0] gap_cnt;
    logic       shift_start;
    logic       shift_done;
    logic       arb_hit;
    logic       arb_idx;
    logic       owner_valid;
    logic [7:0] sel_data;
    logic       sel_dc;
    logic       sel_last;

    // last_ptr names the most recently granted requester; a tie goes to the other one.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            arb_hit = 1'b1;
            arb_idx = ~last_ptr;
        end else if (req0_valid) begin
            arb_hit = 1'b1;
            arb_idx = 1'b0;
        end else if (req1_valid) begin
            arb_hit = 1'b1;
            arb_idx = 1'b1;
        end
    end

    assign owner_valid = (grant[0] && req0_valid) || (grant[1] && req1_valid);
    assign sel_data    = grant[1] ? req1_data : req0_data;
    assign sel_dc      = grant[1] ? req1_dc   : req0_dc;
    assign sel_last    = grant[1] ? req1_last : req0_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        busy        = (state != IDLE);
        shift_start = (state == LOAD);
        req0_ready  = (state == LOAD) && grant[0];
        req1_ready  = (state == LOAD) && grant[1];
        case (state)
            IDLE: begin
                if (grant == 2'b00) begin
                    if (arb_hit) begin
                        next_state = LOAD;
                    end
                end else if (owner_valid) begin
                    next_state = LOAD;
                end
            end
            LOAD:    next_state = SHIFT;
            SHIFT:   if (shift_done) next_state = GAP;
            GAP:     if (gap_cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A lock persists across IDLE until a byte tagged last has cleared GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= 2'b00;
            last_ptr <= 1'b1;
            dc       <= 1'b0;
            last_cap <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant == 2'b00 && arb_hit) begin
                        grant    <= arb_idx ? 2'b10 : 2'b01;
                        last_ptr <= arb_idx;
                    end
                end
                LOAD: begin
                    dc       <= sel_dc;
                    last_cap <= sel_last;
                    gap_cnt  <= '0;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (last_cap) begin
                            grant <= 2'b00;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    oled_spi_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (shift_start),
        .tx_byte (sel_data),
        .sclk    (sclk),
        .sdo     (sdo),
        .done    (shift_done)
    );

endmodule
